// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller, the button front end,
// the BCD counter chain and the display scanner.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_lap;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       count_en;
  logic       count_clr;
  logic [3:0] disp3;
  logic [3:0] disp2;
  logic [3:0] disp1;
  logic [3:0] disp0;
  logic       running;
  logic [2:0] state;
  logic       disp_blank;

  modport master (
    output btn_start, btn_lap, digit3, digit2, digit1, digit0,
    input  count_en, count_clr, disp3, disp2, disp1, disp0,
           running, state, disp_blank
  );

  modport slave (
    input  btn_start, btn_lap, digit3, digit2, digit1, digit0,
    output count_en, count_clr, disp3, disp2, disp1, disp0,
           running, state, disp_blank
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch sequencer: button FSM, 1 Hz tick prescaler and lap freeze.
// Define STOPWATCH_PAUSE_BLINK_EN to blink the display while paused or done.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int PRE_WIDTH = 27
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [PRE_WIDTH-1:0] pre_q;
  logic [3:0]           lap3_q, lap2_q, lap1_q, lap0_q;
  logic                 full;
  logic                 counting;
  logic                 pre_wrap;
  logic                 lap_capture;
  logic                 to_idle;
  logic                 count_en_q;
  logic                 count_clr_q;

  assign full     = (bus.digit3 == 4'd5) && (bus.digit2 == 4'd9) &&
                    (bus.digit1 == 4'd5) && (bus.digit0 == 4'd9);
  assign counting = (state_q == RUN) || (state_q == LAP);
  assign pre_wrap = (pre_q == PRE_WIDTH'(TICK_DIV - 1));

  // Start beats lap when both arrive together; a full counter beats both.
  always_comb begin
    state_d     = state_q;
    lap_capture = 1'b0;
    case (state_q)
      IDLE:  if (bus.btn_start) state_d = RUN;
      RUN: begin
        if (full)               state_d = DONE;
        else if (bus.btn_start) state_d = PAUSE;
        else if (bus.btn_lap) begin
          state_d     = LAP;
          lap_capture = 1'b1;
        end
      end
      LAP: begin
        if (full)               state_d = DONE;
        else if (bus.btn_start) state_d = PAUSE;
        else if (bus.btn_lap)   state_d = RUN;
      end
      PAUSE: begin
        if (bus.btn_start)      state_d = RUN;
        else if (bus.btn_lap)   state_d = IDLE;
      end
      DONE:  if (bus.btn_lap)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  assign to_idle = ((state_q == PAUSE) || (state_q == DONE)) && (state_d == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Prescaler holds outside RUN/LAP so a resume keeps the fractional second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
    end else begin
      if (state_q == IDLE)  pre_q <= '0;
      else if (counting)    pre_q <= pre_wrap ? '0 : pre_q + 1'b1;
      count_en_q  <= counting && pre_wrap && !full;
      count_clr_q <= to_idle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {lap3_q, lap2_q, lap1_q, lap0_q} <= '0;
    end else if (to_idle) begin
      {lap3_q, lap2_q, lap1_q, lap0_q} <= '0;
    end else if (lap_capture) begin
      {lap3_q, lap2_q, lap1_q, lap0_q} <= {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    end
  end

  always_comb begin
    bus.count_en  = count_en_q;
    bus.count_clr = count_clr_q;
    bus.running   = counting;
    bus.state     = state_q;
    if (state_q == LAP) begin
      {bus.disp3, bus.disp2, bus.disp1, bus.disp0} = {lap3_q, lap2_q, lap1_q, lap0_q};
    end else begin
      {bus.disp3, bus.disp2, bus.disp1, bus.disp0} = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    end
  end

`ifdef STOPWATCH_PAUSE_BLINK_EN
  localparam int HALF = TICK_DIV / 2;

  logic [PRE_WIDTH-1:0] half_q;
  logic                 blank_q;
  logic                 held_d;
  logic                 held_q;

  assign held_d = (state_d == PAUSE) || (state_d == DONE);
  assign held_q = (state_q == PAUSE) || (state_q == DONE);

  // Blank starts lit-off on entry, then toggles every half tick period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q  <= '0;
      blank_q <= 1'b0;
    end else if (!held_d) begin
      half_q  <= '0;
      blank_q <= 1'b0;
    end else if (!held_q) begin
      half_q  <= '0;
      blank_q <= 1'b1;
    end else if (half_q == PRE_WIDTH'(HALF - 1)) begin
      half_q  <= '0;
      blank_q <= ~blank_q;
    end else begin
      half_q  <= half_q + 1'b1;
    end
  end

  assign bus.disp_blank = blank_q;
`else
  assign bus.disp_blank = 1'b0;
`endif

endmodule
